fdiv_iter: RTL and testbench

Iterative single-precision (IEEE-754 binary32) divider, y = x1 / x2. It is the inverse-operation companion to the combinational multiplier in the FPU.
- Mantissa quotient uses a restoring shift-subtract loop, one quotient bit per clock.
- Exposes the same y/ovf result convention as the multiplier.
- Sits in the FPU execute stage behind a req/ready/valid handshake, because it is multi-cycle.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fdiv_iter_if.sv | 13 +
 rtl/fdiv_round.sv | 42 ++++
 rtl/fdiv_iter.sv | 152 +++++++++++++++
 tb/tb_fdiv_iter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the iterative divider.
// FDIV_RADIX4_EN selects two restoring steps per CALC cycle instead of one.
package fpu_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RND, DONE} fdiv_state_t;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;
  localparam int REM_W = 26;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int ITER = 25;

`ifdef FDIV_RADIX4_EN
  localparam int QUO_W = 26;
  localparam int STEPS = 13;
`else
  localparam int QUO_W = ITER;
  localparam int STEPS = ITER;
`endif

  // One restoring step: returns {quotient_bit, next_remainder}.
  function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] r,
                                               input logic [SIG_W-1:0] mb);
    if (r >= {2'b00, mb}) div_step = {1'b1, (r - {2'b00, mb}) << 1};
    else                  div_step = {1'b0, r << 1};
  endfunction

endpackage

// File: rtl/fdiv_iter_if.sv
// Request/result handshake bundle between the FPU execute stage and fdiv_iter.
interface fdiv_iter_if;
  logic        req;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        ready;
  logic        valid;
  logic [31:0] y;
  logic        ovf;

  modport master (output req, x1, x2, input ready, valid, y, ovf);
  modport slave  (input req, x1, x2, output ready, valid, y, ovf);
endinterface

// File: rtl/fdiv_round.sv
// Round-to-nearest-even, exponent clamp and binary32 packing; res = {y, ovf}.
// With FDIV_RADIX4_EN the extra low quotient bit folds into sticky.
module fdiv_round
  import fpu_pkg::*;
(
  input  logic [QUO_W-1:0] q,
  input  logic [REM_W-1:0] r,
  input  logic signed [9:0] et,
  input  logic              sy,
  output logic [32:0]       res
);

  logic [SIG_W-1:0] mant;
  logic             guard;
  logic             sticky;
  logic             up;
  logic [SIG_W:0]   sum;
  logic signed [9:0] ef;
  logic             unused_hidden;

  always_comb begin
`ifdef FDIV_RADIX4_EN
    mant   = q[QUO_W-1:2];
    guard  = q[1];
    sticky = q[0] | (|r);
`else
    mant   = q[QUO_W-1:1];
    guard  = q[0];
    sticky = |r;
`endif
    up  = guard & (sticky | mant[0]);
    sum = {1'b0, mant} + {{SIG_W{1'b0}}, up};
    // a carry out leaves sum[22:0] at zero, so only the exponent moves
    ef  = sum[SIG_W] ? et + 10'sd1 : et;
    if (ef >= 10'sd255)   res = {sy, EXP_MAX, 23'd0, 1'b1};
    else if (ef <= 10'sd0) res = {sy, 31'd0, 1'b0};
    else                   res = {sy, ef[7:0], sum[MAN_W-1:0], 1'b0};
  end

  assign unused_hidden = sum[MAN_W];

endmodule

// File: rtl/fdiv_iter.sv
// Iterative binary32 divider y = x1 / x2, restoring loop, req/ready/valid handshake.
// Define FDIV_RADIX4_EN for two quotient bits per cycle (13 CALC cycles).
//   state | meaning
//   IDLE  | waiting for req, ready=1
//   CALC  | restoring shift-subtract iterations
//   RND   | round, clamp and register result
//   DONE  | valid pulse, ready=1 for back-to-back accept
module fdiv_iter
  import fpu_pkg::*;
(
  input logic        clk,
  input logic        rstn,
  fdiv_iter_if.slave bus
);

  fdiv_state_t state, state_nxt;
  logic              ready, valid, accept;
  logic [4:0]        cnt;
  logic [REM_W-1:0]  r, r_ld, r_nxt;
  logic [SIG_W-1:0]  mb, ma_ld, mb_ld;
  logic [QUO_W-1:0]  q, q_nxt;
  logic signed [9:0] et, et_ld;
  logic              sy, sy_in;
  logic [31:0]       y, sp_y;
  logic              ovf, sp_ovf, special;
  logic [32:0]       rnd_res;
  logic [REM_W:0]    step_a;
  logic [7:0]        e1, e2;
  logic [22:0]       m1, m2;
  logic              n1, n2, i1, i2, z1, z2;

  assign e1 = bus.x1[30:23];
  assign e2 = bus.x2[30:23];
  assign m1 = bus.x1[22:0];
  assign m2 = bus.x2[22:0];
  assign n1 = (e1 == EXP_MAX) && (m1 != '0);
  assign n2 = (e2 == EXP_MAX) && (m2 != '0);
  assign i1 = (e1 == EXP_MAX) && (m1 == '0);
  assign i2 = (e2 == EXP_MAX) && (m2 == '0);
  assign z1 = (e1 == '0);
  assign z2 = (e2 == '0);
  assign sy_in = bus.x1[31] ^ bus.x2[31];
  assign accept = bus.req & ready;

  // Subnormals count as zero because z1/z2 only look at the exponent.
  always_comb begin
    special = 1'b1;
    sp_ovf  = 1'b0;
    sp_y    = '0;
    if (n1)                         sp_y = {bus.x1[31], EXP_MAX, 1'b1, m1[21:0]};
    else if (n2)                    sp_y = {bus.x2[31], EXP_MAX, 1'b1, m2[21:0]};
    else if ((i1 && i2) || (z1 && z2)) sp_y = QNAN;
    else if (i1)                    sp_y = {sy_in, EXP_MAX, 23'd0};
    else if (i2)                    sp_y = {sy_in, 31'd0};
    else if (z2) begin
      sp_y   = {sy_in, EXP_MAX, 23'd0};
      sp_ovf = 1'b1;
    end
    else if (z1)                    sp_y = {sy_in, 31'd0};
    else                            special = 1'b0;
  end

  always_comb begin
    ma_ld = {1'b1, m1};
    mb_ld = {1'b1, m2};
    et_ld = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'(EXP_BIAS);
    r_ld  = {2'b00, ma_ld};
    if (ma_ld < mb_ld) begin
      r_ld  = {1'b0, ma_ld, 1'b0};
      et_ld = et_ld - 10'sd1;
    end
  end

  always_comb begin
    step_a = div_step(r, mb);
`ifdef FDIV_RADIX4_EN
    begin
      logic [REM_W:0] step_b;
      step_b = div_step(step_a[REM_W-1:0], mb);
      r_nxt  = step_b[REM_W-1:0];
      q_nxt  = {q[QUO_W-3:0], step_a[REM_W], step_b[REM_W]};
    end
`else
    r_nxt = step_a[REM_W-1:0];
    q_nxt = {q[QUO_W-2:0], step_a[REM_W]};
`endif
  end

  fdiv_round u_round (
    .q   (q),
    .r   (r),
    .et  (et),
    .sy  (sy),
    .res (rnd_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
      CALC:       if (cnt == '0) state_nxt = RND;
      RND:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      r   <= '0;
      mb  <= '0;
      q   <= '0;
      et  <= '0;
      sy  <= 1'b0;
      y   <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      cnt <= 5'(STEPS - 1);
      r   <= r_ld;
      mb  <= mb_ld;
      q   <= '0;
      et  <= et_ld;
      sy  <= sy_in;
      if (special) begin
        y   <= sp_y;
        ovf <= sp_ovf;
      end
    end else if (state == CALC) begin
      r <= r_nxt;
      q <= q_nxt;
      if (cnt != '0) cnt <= cnt - 5'd1;
    end else if (state == RND) begin
      {y, ovf} <= rnd_res;
    end
  end

  assign bus.ready = ready;
  assign bus.valid = valid;
  assign bus.y     = y;
  assign bus.ovf   = ovf;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed cases plus random operands against a quotient/remainder model.
// Build with FDIV_RADIX4_EN defined to check the two-bits-per-cycle variant.
module tb_fdiv_iter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

`ifdef FDIV_RADIX4_EN
  localparam int NORM_LAT = 14;
`else
  localparam int NORM_LAT = 26;
`endif
  localparam int TIMEOUT = 60;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        o;
  } sp_t;

  fdiv_iter_if bus ();

  fdiv_iter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact integer quotient and remainder, RNE, then clamp / flush.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ry, output logic ro, output int rlat);
    logic   s;
    int     ea, eb, e;
    longint num, den, qi, rem;
    s    = a[31] ^ b[31];
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    ro   = 1'b0;
    rlat = 0;
    ry   = '0;
    if (ea == 0 && eb == 0) ry = 32'h7FC00000;
    else if (eb == 0) begin
      ry = {s, 8'hFF, 23'd0};
      ro = 1'b1;
    end
    else if (ea == 0) ry = {s, 31'd0};
    else begin
      rlat = NORM_LAT;
      num  = longint'({1'b1, a[22:0]});
      den  = longint'({1'b1, b[22:0]});
      e    = ea - eb + 127;
      if (num < den) begin
        num = num * 2;
        e   = e - 1;
      end
      qi  = (num << 23) / den;
      rem = (num << 23) % den;
      if (2 * rem > den || (2 * rem == den && (qi % 2) == 1)) qi = qi + 1;
      if (qi == (longint'(1) << 24)) begin
        qi = longint'(1) << 23;
        e  = e + 1;
      end
      if (e >= 255) begin
        ry = {s, 8'hFF, 23'd0};
        ro = 1'b1;
      end
      else if (e <= 0) ry = {s, 31'd0};
      else             ry = {s, 8'(e), 23'(qi)};
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [7:0] e;
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'($urandom_range(1, 4));
    else if (sel == 2) e = 8'($urandom_range(250, 254));
    else if (sel < 8)  e = 8'($urandom_range(110, 144));
    else               e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.req = 1'b1;
    bus.x1  = a;
    bus.x2  = b;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.x1  = $urandom;
    bus.x2  = $urandom;
  endtask

  // edges = rising edges after the accept edge before valid is seen high.
  task automatic wait_valid(output int edges, output bit busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    while (bus.valid !== 1'b1 && edges < TIMEOUT) begin
      if (bus.ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    if (bus.valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: valid=%b after %0d edges, required 1", bus.valid, edges);
    end
  endtask

  task automatic test_reset;
    bus.req = 1'b0;
    bus.x1  = '0;
    bus.x2  = '0;
    rstn    = 1'b0;
    #12;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.ready); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.valid); end
    n_checks++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL reset_y: got %h, required 00000000", bus.y); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int ed;
    bit bz;
    start_op(32'h40C00000, 32'h40000000);
    wait_valid(ed, bz);
    n_checks++; if (bus.y !== 32'h40400000) begin n_fail++; $display("FAIL div6_2_y: got %h, required 40400000", bus.y); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL div6_2_ovf: got %b, required 0", bus.ovf); end
    n_checks++; if (ed != NORM_LAT) begin n_fail++; $display("FAIL div6_2_latency: got %0d, required %0d", ed, NORM_LAT); end
    n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL div6_2_busy: ready seen high while busy, required low"); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b, required 0", bus.valid); end
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b, required 1", bus.ready); end

    start_op(32'h3F800000, 32'h40400000);
    wait_valid(ed, bz);
    n_checks++; if (bus.y !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL div1_3_y: got %h, required 3EAAAAAB", bus.y); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL div1_3_ovf: got %b, required 0", bus.ovf); end
    start_op(32'h3F800000, 32'h3F800000);
    n_checks++; if (bus.y !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL y_hold: got %h, required 3EAAAAAB", bus.y); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_low: got %b, required 0", bus.valid); end
    wait_valid(ed, bz);
    n_checks++; if (bus.y !== 32'h3F800000) begin n_fail++; $display("FAIL b2b_y: got %h, required 3F800000", bus.y); end
    n_checks++; if (ed != NORM_LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d, required %0d", ed, NORM_LAT); end
  endtask

  task automatic test_special;
    int  ed;
    bit  bz;
    sp_t tab[11];
    tab = '{
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1},
      '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0},
      '{32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b0},
      '{32'hBF800000, 32'h00000001, 32'hFF800000, 1'b1},
      '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0},
      '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0},
      '{32'h3F800000, 32'h7F812345, 32'h7FC12345, 1'b0},
      '{32'h80000000, 32'h40400000, 32'h80000000, 1'b0},
      '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0},
      '{32'h7FA00000, 32'h7F812345, 32'h7FE00000, 1'b0}
    };
    foreach (tab[i]) begin
      start_op(tab[i].a, tab[i].b);
      wait_valid(ed, bz);
      n_checks++; if (bus.y !== tab[i].y) begin n_fail++; $display("FAIL special_%0d_y: got %h, required %h", i, bus.y, tab[i].y); end
      n_checks++; if (bus.ovf !== tab[i].o) begin n_fail++; $display("FAIL special_%0d_ovf: got %b, required %b", i, bus.ovf, tab[i].o); end
      n_checks++; if (ed != 0) begin n_fail++; $display("FAIL special_%0d_latency: got %0d, required 0", i, ed); end
    end
  endtask

  task automatic test_ovf_unf;
    int ed;
    bit bz;
    start_op(32'h7F7FFFFF, 32'h3F000000);
    wait_valid(ed, bz);
    n_checks++; if ({bus.y, bus.ovf} !== {32'h7F800000, 1'b1}) begin n_fail++; $display("FAIL overflow: got y=%h ovf=%b, required y=7F800000 ovf=1", bus.y, bus.ovf); end
    n_checks++; if (ed != NORM_LAT) begin n_fail++; $display("FAIL overflow_latency: got %0d, required %0d", ed, NORM_LAT); end
    start_op(32'h00800000, 32'h40000000);
    wait_valid(ed, bz);
    n_checks++; if ({bus.y, bus.ovf} !== {32'h00000000, 1'b0}) begin n_fail++; $display("FAIL underflow: got y=%h ovf=%b, required y=00000000 ovf=0", bus.y, bus.ovf); end
    start_op(32'h80800000, 32'h40000000);
    wait_valid(ed, bz);
    n_checks++; if ({bus.y, bus.ovf} !== {32'h80000000, 1'b0}) begin n_fail++; $display("FAIL underflow_neg: got y=%h ovf=%b, required y=80000000 ovf=0", bus.y, bus.ovf); end
  endtask

  task automatic test_reset_mid;
    int ed;
    bit bz;
    bit seen;
    start_op(32'h40C00000, 32'h40000000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b, required 1", bus.ready); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b, required 0", bus.valid); end
    n_checks++; if (bus.y !== 32'h0) begin n_fail++; $display("FAIL midreset_y: got %h, required 00000000", bus.y); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_valid: valid pulse seen, required none"); end
    start_op(32'h40C00000, 32'h40000000);
    wait_valid(ed, bz);
    n_checks++; if (bus.y !== 32'h40400000) begin n_fail++; $display("FAIL after_reset_y: got %h, required 40400000", bus.y); end
  endtask

  task automatic test_req_busy;
    int ed;
    bit bz;
    bit seen;
    start_op(32'h40C00000, 32'h40000000);
    bus.req = 1'b1;
    bus.x1  = 32'h41000000;
    bus.x2  = 32'h40000000;
    wait_valid(ed, bz);
    bus.req = 1'b0;
    n_checks++; if (bus.y !== 32'h40400000) begin n_fail++; $display("FAIL busy_req_y: got %h, required 40400000", bus.y); end
    n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL busy_req_ready: ready seen high while busy, required low"); end
    seen = 1'b0;
    repeat (NORM_LAT + 4) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL busy_req_queued: extra valid seen, required none"); end
    n_checks++; if (bus.y !== 32'h40400000) begin n_fail++; $display("FAIL busy_req_hold: got %h, required 40400000", bus.y); end
  endtask

  task automatic test_random;
    int          ed, elat;
    bit          bz;
    logic [31:0] a, b, ey;
    logic        eo;
    for (int i = 0; i < 1500; i++) begin
      a = gen_operand();
      b = gen_operand();
      ref_div(a, b, ey, eo, elat);
      start_op(a, b);
      wait_valid(ed, bz);
      n_checks++;
      if ({bus.y, bus.ovf} !== {ey, eo}) begin
        n_fail++;
        $display("FAIL rand_%0d %h/%h: got y=%h ovf=%b, required y=%h ovf=%b", i, a, b, bus.y, bus.ovf, ey, eo);
      end
      n_checks++;
      if (ed != elat) begin
        n_fail++;
        $display("FAIL rand_%0d_latency: got %0d, required %0d", i, ed, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_ovf_unf();
    test_reset_mid();
    test_req_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
